cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter sharing the single Common Data Bus (CDB) between NUM_REQS result producers: functional units, load queue and similar.
- Each producer raises a level request. The arbiter returns a registered one-hot grant.
- In the cycle its grant is high, the winner drives the tri-state CDB (data/addr/tag/redirect/en). All other producers stay at high-Z.
- Sits between the execute stage and the CDB. The arbiter_if req/gnt pairs are flattened into the i_req/o_gnt vectors.

Parameters:
- NUM_REQS, 4, number of CDB requesters; legal range 2..16.
- IDX_WIDTH, $clog2(NUM_REQS), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- i_flush  input  1  pipeline flush: CDB redirect seen by the ROB; kills pending grant selection.
- i_req  input  NUM_REQS  bit i high = requester i holds an undelivered result.
- o_gnt  output  NUM_REQS  registered one-hot grant; bit i high = requester i owns the CDB this cycle.
- o_gnt_valid  output  1  OR of o_gnt.
- o_gnt_idx  output  IDX_WIDTH  binary index of the granted requester; 0 when o_gnt_valid is low.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - One clock; reset is asynchronous and active-high.
  - Reset values: o_gnt = 0, o_gnt_valid = 0, o_gnt_idx = 0, priority pointer ptr_q = 0.
  - Reset asserted mid-operation drops any grant immediately (asynchronous). The first possible grant is the cycle after the first clk edge with rst low.
- State:
  - ptr_q (IDX_WIDTH): highest-priority requester index.
  - gnt_q (NUM_REQS): registered grant.
- Selection (combinational each cycle):
  - Scan i_req starting at ptr_q, ascending with wrap NUM_REQS-1 -> 0.
  - The first set bit is the winner w.
- Update at each clk edge:
  - If i_flush: gnt_q <= 0; ptr_q unchanged.
  - Else if any i_req: gnt_q <= onehot(w); ptr_q <= (w == NUM_REQS-1) ? 0 : w+1.
  - Else: gnt_q <= 0; ptr_q unchanged.
- Latency and handshake:
  - Request at cycle t -> earliest grant at t+1.
  - The requester treats a grant as a one-cycle ownership pulse and broadcasts exactly one result in that cycle.
  - i_req in a grant cycle means an additional result is pending. The requester must drop req in the same cycle if it has no further result; otherwise the arbiter grants it again.
  - Requesters must not withdraw req before being granted, except on flush.
  - Back-to-back grants to the same requester are allowed only when no other requester is waiting, because ptr_q moves past the winner.
- Fairness: with all NUM_REQS requesting continuously, grants rotate 0,1,..,N-1,0. Worst-case wait is NUM_REQS cycles.
- Mutual exclusion: at most one o_gnt bit high in any cycle, which guarantees no multiple drivers on the tri-state CDB. An assertion enforces $onehot0(o_gnt).
- Flush:
  - An i_flush high at edge t suppresses the grant at t+1 regardless of i_req.
  - A grant already high during the flush cycle completes; the ROB discards that result by tag.
  - The pointer is preserved, so post-flush priority continues the rotation.
- o_gnt_idx and o_gnt_valid are registered alongside gnt_q, not decoded after the flop.
- Requests for indices >= NUM_REQS do not exist; no out-of-range handling is needed.

Decomposition:
- No new package types are required. The CDB and arbiter_if definitions remain in package types and the shared interface file.
- One sub-module, rr_pick: combinational round-robin find-first.
  - Inputs: req vector, ptr. Outputs: one-hot winner, winner index, any.
  - Reused later for the reservation-station issue select.

Test Plan:
- Reset: rst high with i_req=4'b1111 -> o_gnt=0, o_gnt_valid=0, o_gnt_idx=0. Deassert rst -> next cycle o_gnt=4'b0001.
- Single requester: i_req=4'b0100 for one cycle, then dropped on grant -> o_gnt=4'b0100, o_gnt_idx=2 for exactly one cycle, then 0.
- Rotation: i_req=4'b1111 held for 8 cycles -> o_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Skip and wrap: ptr=3, i_req=4'b0101 -> grant 0001 (wrap from 3 to 0), then 0100; i_req=4'b1000 alone afterward -> 1000.
- Flush: i_req=4'b0011 with i_flush high for one cycle -> following cycle o_gnt=0. Next cycle grants continue from the preserved pointer (e.g. 0001 if ptr was 0).
- Asynchronous reset mid-grant: o_gnt=4'b0010, rst pulsed between edges -> o_gnt drops to 0 without waiting for clk, and ptr returns to 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its round-robin picker.
package cdb_arbiter_pkg;

    // Default number of CDB requesters and the legal range for that count.
    localparam int CDB_NUM_REQS_DEFAULT = 4;
    localparam int CDB_NUM_REQS_MIN     = 2;
    localparam int CDB_NUM_REQS_MAX     = 16;

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin find-first.
// Scans req starting at ptr, ascending with wrap, and returns the first set bit
// as a one-hot vector, as a binary index, and an any-request flag.
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N = CDB_NUM_REQS_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // rot_req[k] = req[(ptr + k) mod N], so position 0 holds the top priority.
    logic [N-1:0] rot_req;
    logic [W-1:0] off;
    logic [W:0]   idx_sum;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [W:0]   sum;
            logic [W-1:0] src;
            assign sum          = {1'b0, ptr} + (W+1)'(gi);
            assign src          = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
            assign rot_req[gi]  = req[src];
        end
    endgenerate

    // Lowest set position in the rotated vector is the winner's offset from ptr.
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                off = W'(k);
                any = 1'b1;
            end
        end
    end

    // Map the offset back to an absolute requester index and one-hot vector.
    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, off};
        idx     = (idx_sum >= (W+1)'(N)) ? W'(idx_sum - (W+1)'(N)) : W'(idx_sum);
        gnt     = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
        if (!any) begin
            idx = '0;
        end
    end

endmodule : cdb_arbiter_rr_pick

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus.
// Grants are registered one-hot pulses; the winner owns the tri-state CDB for
// exactly the cycle its grant bit is high. The priority pointer moves just past
// each winner so continuous requesters rotate fairly.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQS  = CDB_NUM_REQS_DEFAULT,
    parameter int IDX_WIDTH = $clog2(NUM_REQS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic [NUM_REQS-1:0]  i_req,
    output logic [NUM_REQS-1:0]  o_gnt,
    output logic                 o_gnt_valid,
    output logic [IDX_WIDTH-1:0] o_gnt_idx
);

    logic [IDX_WIDTH-1:0] ptr_reg;
    logic [NUM_REQS-1:0]  gnt_reg;
    logic                 gnt_valid_reg;
    logic [IDX_WIDTH-1:0] gnt_idx_reg;

    logic [NUM_REQS-1:0]  pick_gnt;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_any;
    logic [IDX_WIDTH-1:0] ptr_next;

    cdb_arbiter_rr_pick #(
        .N (NUM_REQS),
        .W (IDX_WIDTH)
    ) u_pick (
        .req (i_req),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Pointer lands one past the winner, wrapping the last requester to 0.
    always_comb begin
        ptr_next = (pick_idx == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Grant, its index/valid companions and the pointer update together;
    // a flush kills the selection but keeps the rotation position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= '0;
        end else if (i_flush || !pick_any) begin
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            gnt_reg       <= pick_gnt;
            gnt_valid_reg <= 1'b1;
            gnt_idx_reg   <= pick_idx;
        end
    end

    assign o_gnt       = gnt_reg;
    assign o_gnt_valid = gnt_valid_reg;
    assign o_gnt_idx   = gnt_idx_reg;

    // Two grant bits high would mean two drivers on the tri-state CDB.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_reg));

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations, then randomized requests/flushes against a behavioural model.
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic         i_flush;
    logic [N-1:0] i_req;
    logic [N-1:0] o_gnt;
    logic         o_gnt_valid;
    logic [W-1:0] o_gnt_idx;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Behavioural model state
    int           m_ptr = 0;
    logic [N-1:0] m_gnt = '0;
    int           m_idx = 0;
    int           m_w;

    cdb_arbiter #(.NUM_REQS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_req       (i_req),
        .o_gnt       (o_gnt),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_idx   (o_gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: first requester found scanning upward from the pointer, with wrap.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0;
            m_gnt = '0;
            m_idx = 0;
        end else if (i_flush) begin
            m_gnt = '0;
            m_idx = 0;
        end else begin
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                if (m_w < 0 && i_req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            end
            if (m_w < 0) begin
                m_gnt = '0;
                m_idx = 0;
            end else begin
                m_gnt = '0;
                m_gnt[m_w] = 1'b1;
                m_idx = m_w;
                m_ptr = (m_w + 1) % N;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if (o_gnt !== m_gnt || o_gnt_valid !== (m_gnt != '0) || int'(o_gnt_idx) != m_idx
                || $isunknown({o_gnt, o_gnt_valid, o_gnt_idx})) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=%b idx=%0d",
                         $time, o_gnt, o_gnt_valid, o_gnt_idx, m_gnt, (m_gnt != '0), m_idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic chk_gnt(input string name, input logic [N-1:0] exp);
        chk(name, int'(o_gnt), int'(exp));
    endtask

    initial begin
        rst     = 1'b1;
        i_flush = 1'b0;
        i_req   = 4'b1111;
        step();
        step();
        // Reset holds everything low even with all requests up
        chk_gnt("reset_gnt", 4'b0000);
        chk("reset_valid", int'(o_gnt_valid), 0);
        chk("reset_idx", int'(o_gnt_idx), 0);
        cmp_en = 1;

        // Release reset; first edge with rst low grants requester 0
        rst = 1'b0;
        step();
        chk_gnt("first_grant", 4'b0001);
        chk("first_valid", int'(o_gnt_valid), 1);

        // Rotation with all requesting
        begin
            logic [N-1:0] rot_exp [7];
            rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
            for (int i = 0; i < 7; i++) begin
                step();
                chk_gnt($sformatf("rotation_%0d", i), rot_exp[i]);
            end
        end

        // Single requester, dropped on grant (pointer now 0)
        i_req = 4'b0100;
        step();
        chk_gnt("single_gnt", 4'b0100);
        chk("single_idx", int'(o_gnt_idx), 2);
        i_req = 4'b0000;
        step();
        chk_gnt("single_drop", 4'b0000);
        chk("single_drop_valid", int'(o_gnt_valid), 0);

        // Pointer now 3: skip and wrap
        i_req = 4'b0101;
        step();
        chk_gnt("wrap_gnt", 4'b0001);
        chk("wrap_idx", int'(o_gnt_idx), 0);
        i_req = 4'b0100;
        step();
        chk_gnt("skip_gnt", 4'b0100);
        i_req = 4'b1000;
        step();
        chk_gnt("last_gnt", 4'b1000);
        chk("last_idx", int'(o_gnt_idx), 3);

        // Flush suppresses next grant, pointer (0) preserved
        i_req   = 4'b0011;
        i_flush = 1'b1;
        step();
        chk_gnt("flush_gnt", 4'b0000);
        i_flush = 1'b0;
        step();
        chk_gnt("post_flush_gnt", 4'b0001);
        step();
        chk_gnt("pre_async_gnt", 4'b0010);

        // Asynchronous reset between edges drops the grant immediately
        #2 rst = 1'b1;
        #1;
        chk_gnt("async_rst_gnt", 4'b0000);
        chk("async_rst_valid", int'(o_gnt_valid), 0);
        rst   = 1'b0;
        i_req = 4'b0110;
        step();
        // Pointer back at 0 selects requester 1 (an unreset pointer of 2 would give 0100)
        chk_gnt("async_rst_ptr", 4'b0010);

        // Randomized requests and flushes, checked against the model
        for (int i = 0; i < 400; i++) begin
            i_req   = N'($urandom_range(0, (1 << N) - 1));
            i_flush = ($urandom_range(0, 7) == 0);
            step();
        end
        i_req   = '0;
        i_flush = 1'b0;
        step();
        step();
        cmp_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cdb_arbiter
